// File: rtl/riscv_retire_unit.sv
// Retirement monitor: counts accepted retirements, exposes the last visible result,
// and latches HALT once the addi/jalr halt pair retires. RETIRE_TRACE_EN adds PC trace ports.
//
// state  | meaning
// IDLE   | no halt-sequence prefix seen
// SAW0   | HALT_INST0 was the last accepted instruction
// HALTED | halt sequence retired; unit frozen until reset
module riscv_retire_unit (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RET_VALID,
    output logic        RET_READY,
    input  logic        RET_FLUSH,
    input  logic [31:0] RET_INST,
    input  logic [1:0]  RET_KIND,
    input  logic [31:0] RET_RESULT,
    input  logic        RET_BR_TAKEN,
`ifdef RETIRE_TRACE_EN
    input  logic [31:0] RET_PC,
    output logic        TRACE_VALID,
    output logic [31:0] TRACE_PC,
`endif
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT
);

    localparam logic [31:0] HALT_INST0 = 32'h00c00093;
    localparam logic [31:0] HALT_INST1 = 32'h00008067;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAW0   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] num_inst_q, num_inst_d;
    logic [31:0] out_port_q, out_port_d;
    logic        accept;

    assign accept = RET_VALID & (state_q != HALTED) & ~RET_FLUSH;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (RET_INST == HALT_INST0) state_d = SAW0;
                end
                SAW0: begin
                    if (RET_INST == HALT_INST1)      state_d = HALTED;
                    else if (RET_INST == HALT_INST0) state_d = SAW0;
                    else                             state_d = IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        num_inst_d = num_inst_q;
        out_port_d = out_port_q;
        if (accept) begin
            // Saturate rather than wrap so a long run never reports a small count.
            if (num_inst_q != 32'hFFFF_FFFF) num_inst_d = num_inst_q + 32'd1;
            case (RET_KIND)
                2'd0, 2'd2: out_port_d = RET_RESULT;
                2'd1:       out_port_d = {31'b0, RET_BR_TAKEN};
                default:    out_port_d = out_port_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            num_inst_q <= 32'd0;
            out_port_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
            out_port_q <= out_port_d;
        end
    end

`ifdef RETIRE_TRACE_EN
    logic        trace_valid_q;
    logic [31:0] trace_pc_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'd0;
        end else begin
            trace_valid_q <= accept;
            if (accept) trace_pc_q <= RET_PC;
        end
    end

    assign TRACE_VALID = trace_valid_q;
    assign TRACE_PC    = trace_pc_q;
`endif

    assign NUM_INST    = num_inst_q;
    assign OUTPUT_PORT = out_port_q;
    assign HALT        = (state_q == HALTED);
    assign RET_READY   = (state_q != HALTED);

endmodule
